// File: rtl/lsu_pkg.sv
// Shared types for the load/store bridge: FSM states, funct3 encodings and access sizes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } acc_size_e;

    function automatic acc_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            F3_LW:         return SZ_WORD;
            default:       return SZ_BAD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: store strobes/replication, load extract/extend, legality check.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    acc_size_e   size;
    logic        sign_ext;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        size     = f3_size(funct3_i);
        sign_ext = ~funct3_i[2];
        byte_v   = rword_i[{addr_lo_i, 3'b000} +: 8];
        half_v   = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

        wstrb_o     = 4'b0000;
        wdata_o     = wdata_i;
        load_data_o = '0;
        case (size)
            SZ_BYTE: begin
                wstrb_o     = 4'b0001 << addr_lo_i;
                wdata_o     = {4{wdata_i[7:0]}};
                load_data_o = {{24{sign_ext & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                wstrb_o     = 4'b0011 << addr_lo_i;
                wdata_o     = {2{wdata_i[15:0]}};
                load_data_o = {{16{sign_ext & half_v[15]}}, half_v};
            end
            SZ_WORD: begin
                wstrb_o     = 4'b1111;
                load_data_o = rword_i;
            end
            default: ;
        endcase
    end

    // Stores only have signed-looking encodings (000/001/010); bit 2 set is illegal for them.
    always_comb begin
        misalign_o = 1'b0;
        if (mem_read_i && mem_write_i) begin
            misalign_o = 1'b1;
        end else if (size == SZ_BAD) begin
            misalign_o = 1'b1;
        end else if (mem_write_i && funct3_i[2]) begin
            misalign_o = 1'b1;
        end else if (size == SZ_WORD && addr_lo_i != 2'b00) begin
            misalign_o = 1'b1;
        end else if (size == SZ_HALF && addr_lo_i[0]) begin
            misalign_o = 1'b1;
        end
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the single-cycle core data port and a wait-state bus.
// Holds the access FSM, the REQ+WAIT timeout counter and the load result register.
module lsu_mem_bridge
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;

    logic        access;
    logic        bad_access;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign access = mem_read | mem_write;

    lsu_lane_align u_lane_align (
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .funct3_i    (funct3),
        .addr_lo_i   (addr[1:0]),
        .wdata_i     (wdata),
        .rword_i     (m_rdata),
        .wstrb_o     (lane_wstrb),
        .wdata_o     (lane_wdata),
        .load_data_o (load_data),
        .misalign_o  (bad_access)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Progress (gnt/rvalid) takes priority over the timeout on the last allowed cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (access) begin
                    if (bad_access) begin
                        state_d    = RESP;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (m_gnt) begin
                    state_d = mem_write ? RESP : WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    bus_err_d = 1'b1;
                    if (mem_read) begin
                        rdata_d = '0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (m_rvalid) begin
                    state_d = RESP;
                    rdata_d = load_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stall   = 1'b0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wstrb = 4'b0000;
        m_wdata = '0;
        case (state_q)
            IDLE: stall = access & ~reset;
            REQ: begin
                stall  = ~reset;
                m_req  = 1'b1;
                m_we   = mem_write;
                m_addr = {addr[31:2], 2'b00};
                if (mem_write) begin
                    m_wstrb = lane_wstrb;
                    m_wdata = lane_wdata;
                end
            end
            WAIT:    stall = ~reset;
            default: stall = 1'b0;
        endcase
    end

    assign rdata    = rdata_q;
    assign misalign = misalign_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Scoreboard bench for lsu_mem_bridge: a wait-state slave model plus per-feature test tasks.
module tb_lsu_mem_bridge;
    import lsu_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, misalign, bus_err;
    logic        m_req, m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    lsu_mem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .misalign(misalign), .bus_err(bus_err), .m_req(m_req), .m_we(m_we),
        .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_gnt(m_gnt),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        misalign;
        logic        bus_err;
        int          stalls;
        logic        bus_cycle;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  strb;
        logic [31:0] bwdata;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = '0;

    int          gnt_delay = 0;
    int          rv_delay = 0;
    logic [31:0] slave_word = '0;
    int          s_req_cnt = 0;
    int          s_rv_cnt = 0;
    bit          s_rv_pend = 0;

    // Slave: grants after gnt_delay REQ cycles, returns read data rv_delay cycles after WAIT starts.
    initial begin
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        forever begin
            @(negedge clk);
            m_gnt    = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = $urandom();
            if (m_req === 1'b1) begin
                if (s_req_cnt == 0) s_rv_pend = 0;
                if (s_req_cnt == gnt_delay) begin
                    m_gnt     = 1'b1;
                    s_rv_pend = (m_we !== 1'b1);
                    s_rv_cnt  = 0;
                end
                s_req_cnt++;
            end else begin
                s_req_cnt = 0;
                if (s_rv_pend) begin
                    if (s_rv_cnt == rv_delay) begin
                        m_rvalid  = 1'b1;
                        m_rdata   = slave_word;
                        s_rv_pend = 0;
                    end else begin
                        s_rv_cnt++;
                    end
                end
            end
        end
    end

    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input int gd,
                             input int rdl, input logic [31:0] word, input string name);
        exp_t        e;
        bit          bad;
        int          total, stalls, cyc;
        bit          saw_req;
        logic        cap_we;
        logic [31:0] cap_addr, cap_wd, shb, shh, ext;
        logic [3:0]  cap_strb;

        bad = (rd && wr) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
              || (wr && f3 > 3'b010) || (f3 == 3'b010 && a[1:0] != 2'b00)
              || ((f3 == 3'b001 || f3 == 3'b101) && a[0]);
        shb = word >> (8 * a[1:0]);
        shh = word >> (16 * a[1]);
        case (f3)
            3'b000:  ext = {{24{shb[7]}}, shb[7:0]};
            3'b100:  ext = {24'h0, shb[7:0]};
            3'b001:  ext = {{16{shh[15]}}, shh[15:0]};
            3'b101:  ext = {16'h0, shh[15:0]};
            default: ext = word;
        endcase
        e.misalign  = bad;
        e.bus_err   = 1'b0;
        e.bus_cycle = !bad;
        e.we        = wr;
        e.baddr     = {a[31:2], 2'b00};
        e.strb      = 4'b0000;
        e.bwdata    = wd;
        if (wr) begin
            case (f3)
                3'b000:  begin e.strb = 4'b0001 << a[1:0]; e.bwdata = {4{wd[7:0]}}; end
                3'b001:  begin e.strb = 4'b0011 << a[1:0]; e.bwdata = {2{wd[15:0]}}; end
                default: e.strb = 4'b1111;
            endcase
        end
        if (bad) begin
            e.stalls = 1;
        end else begin
            total = gd + 1 + (rd ? rdl + 1 : 0);
            if (total > TO) begin
                e.bus_err = 1'b1;
                e.stalls  = 1 + TO;
                if (rd) model_rdata = '0;
            end else begin
                e.stalls = 1 + total;
                if (rd) model_rdata = ext;
            end
        end
        e.rdata = model_rdata;
        sb_q.push_back(e);

        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        gnt_delay = gd; rv_delay = rdl; slave_word = word;
        stalls = 0; cyc = 0; saw_req = 0;
        cap_we = 1'b0; cap_addr = '0; cap_strb = '0; cap_wd = '0;
        #1;
        while (stall === 1'b1 && cyc < 60) begin
            stalls++;
            if (m_req === 1'b1) begin
                saw_req = 1; cap_we = m_we; cap_addr = m_addr; cap_strb = m_wstrb; cap_wd = m_wdata;
            end
            @(negedge clk); #1;
            cyc++;
        end
        if (cyc >= 60) begin
            vectors++; miscompares++;
            $display("FAIL %s no_resp: stall still %b after %0d cycles", name, stall, cyc);
        end
        e = sb_q.pop_front();
        vectors++;
        if (stalls !== e.stalls) begin
            miscompares++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, e.stalls);
        end
        vectors++;
        if (misalign !== e.misalign) begin
            miscompares++; $display("FAIL %s misalign: got %b want %b", name, misalign, e.misalign);
        end
        vectors++;
        if (bus_err !== e.bus_err) begin
            miscompares++; $display("FAIL %s bus_err: got %b want %b", name, bus_err, e.bus_err);
        end
        vectors++;
        if (rdata !== e.rdata) begin
            miscompares++; $display("FAIL %s rdata: got %h want %h", name, rdata, e.rdata);
        end
        vectors++;
        if (saw_req !== e.bus_cycle) begin
            miscompares++; $display("FAIL %s bus_cycle: got %b want %b", name, saw_req, e.bus_cycle);
        end
        if (e.bus_cycle) begin
            vectors++;
            if (cap_we !== e.we || cap_addr !== e.baddr || cap_strb !== e.strb) begin
                miscompares++;
                $display("FAIL %s bus_ctl: got we=%b addr=%h strb=%b want we=%b addr=%h strb=%b",
                         name, cap_we, cap_addr, cap_strb, e.we, e.baddr, e.strb);
            end
            if (wr) begin
                vectors++;
                if (cap_wd !== e.bwdata) begin
                    miscompares++; $display("FAIL %s m_wdata: got %h want %h", name, cap_wd, e.bwdata);
                end
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (misalign !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0 || dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL %s after_resp: got mis=%b err=%b stall=%b state=%0d want 0 0 0 IDLE",
                     name, misalign, bus_err, stall, dut.state_q);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_LW; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (stall !== 1'b0 || m_req !== 1'b0 || m_we !== 1'b0 || m_wstrb !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset outputs: got stall=%b req=%b we=%b strb=%b want all 0", stall, m_req, m_we, m_wstrb);
        end
        vectors++;
        if (rdata !== 32'h0 || misalign !== 1'b0 || bus_err !== 1'b0 || dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL reset regs: got rdata=%h mis=%b err=%b state=%0d want 0 0 0 IDLE",
                     rdata, misalign, bus_err, dut.state_q);
        end
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = '0;
    endtask

    task automatic test_store_word();
        do_access(0, 1, F3_LW, 32'h64, 32'h19, 0, 0, 32'h0, "sw_0x64");
        do_access(0, 1, F3_LH, 32'h66, 32'h0000BEEF, 1, 0, 32'h0, "sh_0x66");
    endtask

    task automatic test_byte_roundtrip();
        do_access(0, 1, F3_LB, 32'h62, 32'hA5, 0, 0, 32'h0, "sb_0x62");
        do_access(1, 0, F3_LBU, 32'h62, 32'h0, 0, 0, 32'h00A50000, "lbu_0x62");
    endtask

    task automatic test_sign_ext();
        do_access(1, 0, F3_LB, 32'h63, 32'h0, 0, 0, 32'h80123456, "lb_0x63");
        do_access(1, 0, F3_LH, 32'h62, 32'h0, 0, 1, 32'h80011234, "lh_0x62");
        do_access(1, 0, F3_LHU, 32'h60, 32'h0, 1, 0, 32'h1234F00D, "lhu_0x60");
        do_access(1, 0, F3_LW, 32'h68, 32'h0, 2, 1, 32'hCAFEBABE, "lw_0x68");
    endtask

    task automatic test_misalign();
        do_access(1, 0, F3_LW, 32'h66, 32'h0, 0, 0, 32'h11111111, "lw_0x66");
        do_access(0, 1, F3_LH, 32'h61, 32'h1234, 0, 0, 32'h0, "sh_0x61");
        do_access(1, 0, F3_LHU, 32'h63, 32'h0, 0, 0, 32'h22222222, "lhu_0x63");
        do_access(1, 0, 3'b011, 32'h60, 32'h0, 0, 0, 32'h33333333, "f3_011");
        do_access(0, 1, F3_LBU, 32'h60, 32'h77, 0, 0, 32'h0, "sbu_illegal");
        do_access(1, 1, F3_LW, 32'h60, 32'h77, 0, 0, 32'h44444444, "rd_and_wr");
    endtask

    task automatic test_timeout();
        do_access(1, 0, F3_LW, 32'h10, 32'h0, 1000, 0, 32'h55555555, "lw_no_gnt");
        do_access(0, 1, F3_LW, 32'h14, 32'h9, TO, 0, 32'h0, "sw_gnt_late");
        do_access(0, 1, F3_LW, 32'h14, 32'h9, TO - 1, 0, 32'h0, "sw_gnt_last");
        do_access(1, 0, F3_LW, 32'h18, 32'h0, 7, 7, 32'h0BADF00D, "lw_rv_last");
        do_access(1, 0, F3_LW, 32'h18, 32'h0, 7, 8, 32'h0BADF00D, "lw_rv_late");
    endtask

    task automatic test_back_to_back();
        logic [2:0] f3s [8];
        f3s = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LB, F3_LH, F3_LW};
        for (int i = 0; i < 16; i++) begin
            int          k;
            logic        w;
            logic [2:0]  f;
            logic [31:0] a;
            k = $urandom_range(0, 7);
            w = (k >= 5);
            f = f3s[k];
            a = 32'h200 + 32'($urandom_range(0, 31));
            do_access(!w, w, f, a, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom(), $sformatf("b2b_%0d", i));
        end
    endtask

    task automatic test_reset_mid();
        bit saw, in_wait, got_rv;
        gnt_delay = 0; rv_delay = 4; slave_word = 32'hDEADBEEF;
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_LW; addr = 32'h20;
        saw = 0; in_wait = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (m_req === 1'b1) saw = 1;
            else if (saw) begin in_wait = 1; break; end
        end
        vectors++;
        if (!in_wait || stall !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid reach_wait: got in_wait=%b stall=%b want 1 1", in_wait, stall);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (m_req !== 1'b0 || stall !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid during_reset: got req=%b stall=%b want 0 0", m_req, stall);
        end
        model_rdata = '0;
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        got_rv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (m_rvalid === 1'b1) begin got_rv = 1; break; end
        end
        vectors++;
        if (!got_rv) begin
            miscompares++; $display("FAIL rst_mid stale_rvalid: got none want a pulse");
        end
        @(posedge clk); #1;
        vectors++;
        if (rdata !== model_rdata || m_req !== 1'b0 || stall !== 1'b0 || dut.state_q !== IDLE) begin
            miscompares++;
            $display("FAIL rst_mid after: got rdata=%h req=%b stall=%b state=%0d want %h 0 0 IDLE",
                     rdata, m_req, stall, dut.state_q, model_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_byte_roundtrip();
        test_sign_ext();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
